// File: rtl/pe_feed_ctrl.sv
// Feed controller for a MAC processing element: streams weight and feature
// beats into the PE as one-cycle write strobes and sequences jobs node by node.
module pe_feed_ctrl #(
  parameter int unsigned MAC_DIM    = 5,
  parameter int unsigned FEAT_WIDTH = 1,
  parameter int unsigned WGT_WIDTH  = 8,
  parameter int unsigned SPAD_WIDTH = 64,
  parameter int unsigned ADDR_WIDTH = $clog2(SPAD_WIDTH),
  parameter int unsigned WGT_INDEX  = $clog2(WGT_WIDTH),
  parameter int unsigned CNT_WIDTH  = 12
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             start,
  input  logic                             load_wgt,
  input  logic [CNT_WIDTH-1:0]             num_nodes,
  input  logic                             wgt_valid,
  output logic                             wgt_ready,
  input  logic [WGT_WIDTH*WGT_WIDTH-1:0]   wgt_data,
  input  logic                             feat_valid,
  output logic                             feat_ready,
  input  logic [FEAT_WIDTH*SPAD_WIDTH-1:0] feat_data,
  input  logic [ADDR_WIDTH*MAC_DIM-1:0]    feat_addr,
  input  logic [2:0]                       feat_nz,
  input  logic                             feat_last,
  input  logic                             pe_out_vd,
  output logic [ADDR_WIDTH*MAC_DIM-1:0]    addr_bus,
  output logic [FEAT_WIDTH*SPAD_WIDTH-1:0] data_bus,
  output logic [2:0]                       non_zero_num,
  output logic                             acc,
  output logic                             done,
  output logic                             w_we,
  output logic                             x_we,
  output logic                             busy,
  output logic                             complete,
  output logic                             nz_err
);

  localparam int unsigned AddrW = ADDR_WIDTH * MAC_DIM;
  localparam int unsigned DataW = FEAT_WIDTH * SPAD_WIDTH;
  localparam logic [2:0] NzMax = 3'(MAC_DIM);
  localparam logic [WGT_INDEX-1:0] LastWgt = WGT_INDEX'(WGT_WIDTH - 1);

  typedef enum logic [2:0] {StIdle, StWload, StFeed, StWaitOut, StFin} state_e;

  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] num_nodes_q, num_nodes_d;
  logic [CNT_WIDTH-1:0] node_cnt_q, node_cnt_d;
  logic [WGT_INDEX-1:0] beat_cnt_q, beat_cnt_d;
  logic                 first_q, first_d;
  logic [AddrW-1:0]     addr_q, addr_d;
  logic [DataW-1:0]     data_q, data_d;
  logic [2:0]           nz_q, nz_d;
  logic                 acc_q, acc_d;
  logic                 done_q, done_d;
  logic                 w_we_q, w_we_d;
  logic                 x_we_q, x_we_d;
  logic                 nz_err_q, nz_err_d;

  logic wgt_hs, feat_hs;

  // Ready depends on state only so the sender never sees a valid->ready path.
  assign wgt_ready  = (state_q == StWload);
  assign feat_ready = (state_q == StFeed);
  assign wgt_hs     = wgt_valid & wgt_ready;
  assign feat_hs    = feat_valid & feat_ready;

  always_comb begin
    state_d     = state_q;
    num_nodes_d = num_nodes_q;
    node_cnt_d  = node_cnt_q;
    beat_cnt_d  = beat_cnt_q;
    first_d     = first_q;
    addr_d      = addr_q;
    data_d      = data_q;
    nz_d        = nz_q;
    acc_d       = acc_q;
    done_d      = done_q;
    w_we_d      = 1'b0;
    x_we_d      = 1'b0;
    nz_err_d    = nz_err_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          num_nodes_d = num_nodes;
          node_cnt_d  = '0;
          beat_cnt_d  = '0;
          first_d     = 1'b1;
          if (num_nodes == '0) begin
            state_d = StFin;
          end else if (load_wgt) begin
            state_d = StWload;
          end else begin
            state_d = StFeed;
          end
        end
      end
      StWload: begin
        if (wgt_hs) begin
          w_we_d                 = 1'b1;
          data_d                 = DataW'(wgt_data);
          addr_d                 = '0;
          addr_d[WGT_INDEX-1:0]  = beat_cnt_q;
          if (beat_cnt_q == LastWgt) begin
            beat_cnt_d = '0;
            state_d    = StFeed;
          end else begin
            beat_cnt_d = beat_cnt_q + WGT_INDEX'(1);
          end
        end
      end
      StFeed: begin
        if (feat_hs) begin
          x_we_d = 1'b1;
          data_d = feat_data;
          addr_d = feat_addr;
          if (feat_nz > NzMax) begin
            nz_d     = NzMax;
            nz_err_d = 1'b1;
          end else begin
            nz_d = feat_nz;
          end
          acc_d   = ~first_q;
          done_d  = feat_last;
          // The beat after a node's last beat opens the next node.
          first_d = feat_last;
          if (feat_last) begin
            state_d = StWaitOut;
          end
        end
      end
      StWaitOut: begin
        if (pe_out_vd) begin
          if (node_cnt_q + CNT_WIDTH'(1) == num_nodes_q) begin
            node_cnt_d = '0;
            state_d    = StFin;
          end else begin
            node_cnt_d = node_cnt_q + CNT_WIDTH'(1);
            state_d    = StFeed;
          end
        end
      end
      StFin: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      num_nodes_q <= '0;
      node_cnt_q  <= '0;
      beat_cnt_q  <= '0;
      first_q     <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      nz_q        <= '0;
      acc_q       <= 1'b0;
      done_q      <= 1'b0;
      w_we_q      <= 1'b0;
      x_we_q      <= 1'b0;
      nz_err_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      num_nodes_q <= num_nodes_d;
      node_cnt_q  <= node_cnt_d;
      beat_cnt_q  <= beat_cnt_d;
      first_q     <= first_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      nz_q        <= nz_d;
      acc_q       <= acc_d;
      done_q      <= done_d;
      w_we_q      <= w_we_d;
      x_we_q      <= x_we_d;
      nz_err_q    <= nz_err_d;
    end
  end

  assign addr_bus     = addr_q;
  assign data_bus     = data_q;
  assign non_zero_num = nz_q;
  assign acc          = acc_q;
  assign done         = done_q;
  assign w_we         = w_we_q;
  assign x_we         = x_we_q;
  assign nz_err       = nz_err_q;
  assign busy         = (state_q != StIdle);
  assign complete     = (state_q == StFin);

endmodule

// File: tb/tb_pe_feed_ctrl.sv
// Self-checking bench for pe_feed_ctrl: directed job scenarios followed by random
// traffic, all checked against a job-level reference model.
module tb_pe_feed_ctrl;

  localparam int MacDim = 5;
  localparam int AddrW  = 30;
  localparam int DataW  = 64;
  localparam int CntW   = 12;

  logic              clk = 1'b0;
  logic              reset;
  logic              start, load_wgt;
  logic [CntW-1:0]   num_nodes;
  logic              wgt_valid, wgt_ready;
  logic [63:0]       wgt_data;
  logic              feat_valid, feat_ready;
  logic [DataW-1:0]  feat_data;
  logic [AddrW-1:0]  feat_addr;
  logic [2:0]        feat_nz;
  logic              feat_last, pe_out_vd;
  logic [AddrW-1:0]  addr_bus;
  logic [DataW-1:0]  data_bus;
  logic [2:0]        non_zero_num;
  logic              acc, done, w_we, x_we, busy, complete, nz_err;

  always #5 clk = ~clk;

  pe_feed_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .load_wgt    (load_wgt),
    .num_nodes   (num_nodes),
    .wgt_valid   (wgt_valid),
    .wgt_ready   (wgt_ready),
    .wgt_data    (wgt_data),
    .feat_valid  (feat_valid),
    .feat_ready  (feat_ready),
    .feat_data   (feat_data),
    .feat_addr   (feat_addr),
    .feat_nz     (feat_nz),
    .feat_last   (feat_last),
    .pe_out_vd   (pe_out_vd),
    .addr_bus    (addr_bus),
    .data_bus    (data_bus),
    .non_zero_num(non_zero_num),
    .acc         (acc),
    .done        (done),
    .w_we        (w_we),
    .x_we        (x_we),
    .busy        (busy),
    .complete    (complete),
    .nz_err      (nz_err)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Job-level model: tracks weights still owed, nodes finished and whether a
  // PE result is pending, plus the PE bus contents last written.
  bit               m_job, m_fin, m_await, m_first, m_err;
  int               m_wleft, m_nodes, m_done;
  logic [AddrW-1:0] e_addr;
  logic [DataW-1:0] e_data;
  logic [2:0]       e_nz;
  bit               e_acc, e_done, e_wwe, e_xwe;

  task automatic model_reset();
    m_job = 0; m_fin = 0; m_await = 0; m_first = 0; m_err = 0;
    m_wleft = 0; m_nodes = 0; m_done = 0;
    e_addr = '0; e_data = '0; e_nz = '0; e_acc = 0; e_done = 0; e_wwe = 0; e_xwe = 0;
  endtask

  task automatic model_step();
    e_wwe = 0;
    e_xwe = 0;
    if (!m_job) begin
      if (start) begin
        m_job = 1; m_nodes = int'(num_nodes); m_done = 0; m_first = 1; m_await = 0;
        m_fin   = (num_nodes == 0);
        m_wleft = (num_nodes != 0 && load_wgt) ? 8 : 0;
      end
    end else if (m_fin) begin
      m_job = 0;
      m_fin = 0;
    end else if (m_wleft > 0) begin
      if (wgt_valid) begin
        e_wwe       = 1;
        e_data      = wgt_data;
        e_addr      = '0;
        e_addr[2:0] = 3'(8 - m_wleft);
        m_wleft--;
      end
    end else if (m_await) begin
      if (pe_out_vd) begin
        m_done++;
        m_await = 0;
        if (m_done == m_nodes) m_fin = 1;
      end
    end else if (feat_valid) begin
      e_xwe  = 1;
      e_data = feat_data;
      e_addr = feat_addr;
      e_nz   = (int'(feat_nz) > MacDim) ? 3'(MacDim) : feat_nz;
      if (int'(feat_nz) > MacDim) m_err = 1;
      e_acc   = !m_first;
      e_done  = feat_last;
      m_first = feat_last;
      if (feat_last) m_await = 1;
    end
  endtask

  // Entered at posedge+1 with inputs already driven; leaves at posedge+1.
  task automatic cycle();
    #1;
    check_eq("wgt_ready", wgt_ready, m_job && !m_fin && m_wleft > 0);
    check_eq("feat_ready", feat_ready, m_job && !m_fin && m_wleft == 0 && !m_await);
    check_eq("busy", busy, m_job);
    check_eq("complete", complete, m_fin);
    @(posedge clk);
    model_step();
    #1;
    check_eq("w_we", w_we, e_wwe);
    check_eq("x_we", x_we, e_xwe);
    check_eq("addr_bus", addr_bus, e_addr);
    check_eq("data_bus", data_bus, e_data);
    check_eq("non_zero_num", non_zero_num, e_nz);
    check_eq("acc", acc, e_acc);
    check_eq("done", done, e_done);
    check_eq("nz_err", nz_err, m_err);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_ready"}, {wgt_ready, feat_ready}, 0);
    check_eq({tag, "_strobes"}, {w_we, x_we, acc, done}, 0);
    check_eq({tag, "_status"}, {busy, complete, nz_err}, 0);
    check_eq({tag, "_addr"}, addr_bus, 0);
    check_eq({tag, "_data"}, data_bus, 0);
    check_eq({tag, "_nz"}, non_zero_num, 0);
  endtask

  task automatic do_reset();
    #2;
    reset = 1'b1;
    #1;
    check_all_zero("async_reset");
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic idle_inputs();
    start = 0; load_wgt = 0; num_nodes = '0; wgt_valid = 0; feat_valid = 0;
    feat_nz = '0; feat_last = 0; pe_out_vd = 0;
    wgt_data = {$urandom, $urandom}; feat_data = {$urandom, $urandom};
    feat_addr = 30'($urandom);
  endtask

  task automatic job_start(input bit load, input int n);
    start = 1; load_wgt = load; num_nodes = CntW'(n);
    cycle();
    start = 0; load_wgt = 0;
  endtask

  task automatic feat_beat(input logic [2:0] nz, input bit last);
    feat_valid = 1; feat_nz = nz; feat_last = last;
    feat_data = {$urandom, $urandom}; feat_addr = 30'($urandom);
    cycle();
    feat_valid = 0; feat_last = 0;
  endtask

  task automatic pe_pulse();
    pe_out_vd = 1;
    cycle();
    pe_out_vd = 0;
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    model_reset();
    #1;
    check_all_zero("reset_state");
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Weight load then one 3-beat node.
    job_start(1, 1);
    wgt_valid = 1;
    for (int k = 0; k < 8; k++) begin
      wgt_data = {$urandom, $urandom};
      cycle();
    end
    wgt_valid = 0;
    feat_beat(3'd5, 0);
    feat_beat(3'd2, 0);
    feat_beat(3'd3, 1);
    repeat (2) cycle();
    pe_pulse();
    repeat (2) cycle();

    // Throttled feature stream.
    job_start(0, 1);
    feat_beat(3'd1, 0);
    cycle();
    feat_beat(3'd4, 0);
    cycle();
    feat_beat(3'd2, 1);
    pe_pulse();
    repeat (2) cycle();

    // Clamp, then nz_err must survive a later clean job.
    job_start(0, 1);
    feat_beat(3'd7, 1);
    check_eq("clamp_nz", non_zero_num, 3'd5);
    pe_pulse();
    repeat (2) cycle();
    job_start(0, 1);
    feat_beat(3'd1, 1);
    check_eq("nz_err_sticky", nz_err, 1);
    pe_pulse();
    repeat (2) cycle();

    // Empty job, then a start pulse arriving mid-job.
    job_start(1, 0);
    repeat (2) cycle();
    job_start(0, 2);
    feat_beat(3'd1, 0);
    job_start(1, 0);
    feat_beat(3'd2, 1);
    pe_pulse();
    feat_beat(3'd3, 1);
    pe_pulse();
    repeat (2) cycle();

    // Reset after beat 2 of 4, then a fresh job.
    job_start(0, 1);
    feat_beat(3'd1, 0);
    feat_beat(3'd2, 0);
    do_reset();
    job_start(0, 1);
    feat_beat(3'd2, 1);
    check_eq("post_reset_acc", acc, 0);
    pe_pulse();
    repeat (2) cycle();

    // Random traffic.
    for (int i = 0; i < 4000; i++) begin
      start      = ($urandom % 4) == 0;
      load_wgt   = $urandom % 2;
      num_nodes  = CntW'($urandom % 4);
      wgt_valid  = ($urandom % 4) != 0;
      wgt_data   = {$urandom, $urandom};
      feat_valid = ($urandom % 3) != 0;
      feat_data  = {$urandom, $urandom};
      feat_addr  = 30'($urandom);
      feat_nz    = 3'($urandom % 8);
      feat_last  = ($urandom % 3) == 0;
      pe_out_vd  = ($urandom % 4) == 0;
      if (($urandom % 400) == 0) begin
        do_reset();
      end else begin
        cycle();
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
